// File: rtl/decoder_scan_pkg.sv
// Shared types and helpers for the decoder_scan block and its prescaler.
//   mode_t : select-input decode or one of the three auto-sequencing modes
//   dir_t  : travel direction used by the bounce sequencer
//   cnt_width() : counter width needed to count 0..div-1 (at least 1 bit)
package decoder_scan_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT    = 2'd0,
    MODE_SCAN_UP   = 2'd1,
    MODE_SCAN_DOWN = 2'd2,
    MODE_BOUNCE    = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  function automatic int unsigned cnt_width(input int unsigned div);
    return (div > 32'd1) ? $clog2(div) : 32'd1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Reusable prescaler: emits a one-cycle tick every DIV enabled clock cycles.
//   clk   : system clock
//   reset : synchronous, active-high; clears count and tick
//   en    : count enable; low clears the count and holds tick low
//   tick  : registered pulse, high on the cycle the count wraps to 0
module tick_gen
  import decoder_scan_pkg::*;
#(
  parameter int unsigned DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned     CW   = cnt_width(DIV);
  localparam logic [CW-1:0]   LAST = CW'(DIV - 32'd1);

  logic [CW-1:0] count_r;
  logic          tick_r;

  assign tick = tick_r;

  // Prescaler counter; the tick is registered alongside the wrap so it
  // lines up with the cycle the count reads 0. DIV=1 ticks every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
      tick_r  <= 1'b0;
    end else if (!en) begin
      count_r <= {CW{1'b0}};
      tick_r  <= 1'b0;
    end else if (count_r == LAST) begin
      count_r <= {CW{1'b0}};
      tick_r  <= 1'b1;
    end else begin
      count_r <= count_r + CW'(1);
      tick_r  <= 1'b0;
    end
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with auto-sequencing (scan up/down, bounce).
//   clk   : system clock
//   reset : synchronous, active-high; dominates every other input
//   en    : output enable; low forces y to zero and freezes sequencing
//   mode  : 0=DIRECT, 1=SCAN_UP, 2=SCAN_DOWN, 3=BOUNCE
//   sel   : decode value in DIRECT, preload value on load
//   load  : single-cycle strobe, idx <= sel (works even with en low)
//   y     : registered one-hot (or zero) output
//   idx   : registered active index
//   tick  : one-cycle prescaler wrap pulse
module decoder_scan
  import decoder_scan_pkg::*;
#(
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned OUT_W    = 2**SEL_W,
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             load,
  output logic [OUT_W-1:0] y,
  output logic [SEL_W-1:0] idx,
  output logic             tick
);

  localparam logic [SEL_W-1:0] IDX_MAX = {SEL_W{1'b1}};
  localparam logic [SEL_W-1:0] IDX_ONE = SEL_W'(1);

  logic [SEL_W-1:0] idx_r;
  logic [SEL_W-1:0] idx_next_s;
  logic [OUT_W-1:0] y_r;
  logic [OUT_W-1:0] y_next_s;
  dir_t             dir_r;
  dir_t             dir_next_s;
  mode_t            mode_s;
  logic             tick_s;

  assign mode_s = mode_t'(mode);
  assign y      = y_r;
  assign idx    = idx_r;
  assign tick   = tick_s;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .tick  (tick_s)
  );

  // Next index/direction: load beats any mode action; with en low only
  // load can move idx. tick is already held low by the prescaler when en
  // is low, but DIRECT does not use tick, hence the explicit en gate.
  always_comb begin
    idx_next_s = idx_r;
    dir_next_s = dir_r;
    if (load) begin
      idx_next_s = sel;
    end else if (!en) begin
      idx_next_s = idx_r;
    end else begin
      case (mode_s)
        MODE_DIRECT: begin
          idx_next_s = sel;
        end
        MODE_SCAN_UP: begin
          if (tick_s) begin
            idx_next_s = idx_r + IDX_ONE;
          end else begin
            idx_next_s = idx_r;
          end
        end
        MODE_SCAN_DOWN: begin
          if (tick_s) begin
            idx_next_s = idx_r - IDX_ONE;
          end else begin
            idx_next_s = idx_r;
          end
        end
        MODE_BOUNCE: begin
          // Endpoints turn around immediately so each end shows for one step.
          if (!tick_s) begin
            idx_next_s = idx_r;
          end else if (dir_r == DIR_UP) begin
            if (idx_r == IDX_MAX) begin
              idx_next_s = IDX_MAX - IDX_ONE;
              dir_next_s = DIR_DOWN;
            end else begin
              idx_next_s = idx_r + IDX_ONE;
            end
          end else begin
            if (idx_r == {SEL_W{1'b0}}) begin
              idx_next_s = IDX_ONE;
              dir_next_s = DIR_UP;
            end else begin
              idx_next_s = idx_r - IDX_ONE;
            end
          end
        end
        default: begin
          idx_next_s = idx_r;
        end
      endcase
    end
  end

  // One-hot decode of the index that is about to be registered.
  always_comb begin
    y_next_s = {OUT_W{1'b0}};
    if (en) begin
      y_next_s = OUT_W'(1) << idx_next_s;
    end else begin
      y_next_s = {OUT_W{1'b0}};
    end
  end

  // Sequencer state and registered output.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r <= {SEL_W{1'b0}};
      dir_r <= DIR_UP;
      y_r   <= {OUT_W{1'b0}};
    end else begin
      idx_r <= idx_next_s;
      dir_r <= dir_next_s;
      y_r   <= y_next_s;
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
module tb_decoder_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: SEL_W=4, TICK_DIV=4
  logic        reset, en, load;
  logic [1:0]  mode;
  logic [3:0]  sel;
  logic [15:0] y;
  logic [3:0]  idx;
  logic        tick;

  // Small instance for bounce: SEL_W=2, TICK_DIV=2
  logic        en2, load2;
  logic [1:0]  mode2;
  logic [1:0]  sel2;
  logic [3:0]  y2;
  logic [1:0]  idx2;
  logic        tick2;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [15:0] y;
    logic [3:0]  idx;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic        en;
    logic        load;
    logic [3:0]  sel;
    logic [15:0] y;
    logic [3:0]  idx;
  } vec_t;
  vec_t vecs[7];

  logic [1:0] bseq[8];

  decoder_scan #(.SEL_W(4), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sel(sel),
    .load(load), .y(y), .idx(idx), .tick(tick)
  );

  decoder_scan #(.SEL_W(2), .TICK_DIV(2)) dut2 (
    .clk(clk), .reset(reset), .en(en2), .mode(mode2), .sel(sel2),
    .load(load2), .y(y2), .idx(idx2), .tick(tick2)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [3:0] e_idx, input logic e_en);
    exp_t e;
    e.idx = e_idx;
    e.y   = e_en ? (16'd1 << e_idx) : 16'd0;
    sbq.push_back(e);
  endtask

  task automatic sb_check(input string nm);
    exp_t e;
    if (sbq.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got idx=%0h want an entry", nm, idx);
    end else begin
      e = sbq.pop_front();
      check({nm, ".y"}, 32'(y), 32'(e.y));
      check({nm, ".idx"}, 32'(idx), 32'(e.idx));
    end
  endtask

  // Step until tick is seen (bounded); idx/y must hold cur while waiting.
  task automatic wait_tick(input logic [3:0] cur, output int n);
    bit found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      n++;
      check("hold.idx", 32'(idx), 32'(cur));
      check("hold.y", 32'(y), 32'(16'd1 << cur));
      if (tick) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_err++;
      $display("FAIL tick_timeout: got no tick in %0d cycles, want one", n);
    end
  endtask

  task automatic scan_seq(input logic [3:0] start, input logic up, input int nsteps);
    logic [3:0] cur, nxt;
    int n;
    cur = start;
    for (int k = 0; k < nsteps; k++) begin
      wait_tick(cur, n);
      if (k > 0) check("tick_gap", 32'(n + 1), 32'd4);
      nxt = up ? cur + 4'd1 : cur - 4'd1;
      expect_out(nxt, 1'b1);
      step();
      sb_check("scan");
      cur = nxt;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b0;
    load2 = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    bit found;

    reset = 1'b1; en = 1'b0; load = 1'b0; mode = 2'd0; sel = 4'd0;
    en2 = 1'b0; load2 = 1'b0; mode2 = 2'd0; sel2 = 2'd0;

    vecs[0] = '{1'b1, 1'b0, 4'h5, 16'h0020, 4'h5};
    vecs[1] = '{1'b1, 1'b0, 4'hF, 16'h8000, 4'hF};
    vecs[2] = '{1'b0, 1'b0, 4'hF, 16'h0000, 4'hF};
    vecs[3] = '{1'b0, 1'b0, 4'h3, 16'h0000, 4'hF};
    vecs[4] = '{1'b0, 1'b1, 4'h3, 16'h0000, 4'h3};
    vecs[5] = '{1'b1, 1'b0, 4'h0, 16'h0001, 4'h0};
    vecs[6] = '{1'b1, 1'b0, 4'h8, 16'h0100, 4'h8};

    bseq[0] = 2'd0; bseq[1] = 2'd1; bseq[2] = 2'd2; bseq[3] = 2'd3;
    bseq[4] = 2'd2; bseq[5] = 2'd1; bseq[6] = 2'd0; bseq[7] = 2'd1;

    // 1: reset state and DIRECT table
    do_reset();
    check("reset.y", 32'(y), 32'd0);
    check("reset.idx", 32'(idx), 32'd0);
    check("reset.tick", 32'(tick), 32'd0);
    mode = 2'd0;
    for (int i = 0; i < 7; i++) begin
      en   = vecs[i].en;
      load = vecs[i].load;
      sel  = vecs[i].sel;
      sbq.push_back('{vecs[i].y, vecs[i].idx});
      step();
      sb_check("direct");
    end
    load = 1'b0;

    // 2: SCAN_UP from 14, then freeze with en=0 and resume
    do_reset();
    en = 1'b1; mode = 2'd1; load = 1'b1; sel = 4'd14;
    expect_out(4'd14, 1'b1);
    step();
    load = 1'b0;
    sb_check("scanup.load");
    scan_seq(4'd14, 1'b1, 3);
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("freeze.y", 32'(y), 32'd0);
      check("freeze.idx", 32'(idx), 32'd1);
      check("freeze.tick", 32'(tick), 32'd0);
    end
    en = 1'b1;
    expect_out(4'd1, 1'b1);
    step();
    sb_check("resume");
    wait_tick(4'd1, n);
    check("resume_gap", 32'(n + 1), 32'd4);
    expect_out(4'd2, 1'b1);
    step();
    sb_check("resume.step");

    // 3: SCAN_DOWN from 1
    do_reset();
    en = 1'b1; mode = 2'd2; load = 1'b1; sel = 4'd1;
    expect_out(4'd1, 1'b1);
    step();
    load = 1'b0;
    sb_check("scandn.load");
    scan_seq(4'd1, 1'b0, 3);

    // 5: load coinciding with tick wins
    do_reset();
    en = 1'b1; mode = 2'd1; load = 1'b1; sel = 4'd0;
    expect_out(4'd0, 1'b1);
    step();
    load = 1'b0;
    sb_check("lt.start");
    wait_tick(4'd0, n);
    load = 1'b1; sel = 4'd9;
    expect_out(4'd9, 1'b1);
    step();
    load = 1'b0;
    sb_check("lt.load");
    wait_tick(4'd9, n);
    check("lt.gap", 32'(n + 1), 32'd4);
    expect_out(4'd10, 1'b1);
    step();
    sb_check("lt.step");

    // 6: reset mid-bounce (dir DOWN) with load asserted
    do_reset();
    en = 1'b1; mode = 2'd3; load = 1'b1; sel = 4'd15;
    expect_out(4'd15, 1'b1);
    step();
    load = 1'b0;
    sb_check("b6.load15");
    wait_tick(4'd15, n);
    expect_out(4'd14, 1'b1);
    step();
    sb_check("b6.turn");
    load = 1'b1; sel = 4'd2;
    expect_out(4'd2, 1'b1);
    step();
    load = 1'b0;
    sb_check("b6.load2");
    wait_tick(4'd2, n);
    expect_out(4'd1, 1'b1);
    step();
    sb_check("b6.down");
    reset = 1'b1; load = 1'b1; sel = 4'd7;
    step();
    reset = 1'b0; load = 1'b0;
    check("b6.rst.idx", 32'(idx), 32'd0);
    check("b6.rst.y", 32'(y), 32'd0);
    check("b6.rst.tick", 32'(tick), 32'd0);
    load = 1'b1; sel = 4'd5;
    expect_out(4'd5, 1'b1);
    step();
    load = 1'b0;
    sb_check("b6.load5");
    wait_tick(4'd5, n);
    check("b6.first_tick", 32'(n + 1), 32'd4);
    expect_out(4'd6, 1'b1);
    step();
    sb_check("b6.dir_up");

    // 4: BOUNCE on SEL_W=2 instance
    en = 1'b0;
    do_reset();
    en2 = 1'b1; mode2 = 2'd3;
    for (int k = 1; k < 8; k++) begin
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        step();
        check("b4.hold", 32'(idx2), 32'(bseq[k-1]));
        if (tick2) found = 1'b1;
      end
      if (!found) begin
        n_checks++;
        n_err++;
        $display("FAIL b4.tick_timeout: got no tick2, want one");
      end
      step();
      check("b4.idx", 32'(idx2), 32'(bseq[k]));
      check("b4.y", 32'(y2), 32'(4'd1 << bseq[k]));
    end

    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/decoder_scan.md
Name: decoder_scan

Overview:
- Parametrised, registered successor to the board-level 4-to-16 decoder. Drives a one-hot output vector, typically the LED bank.
- Decodes a select input directly, or auto-sequences the active bit: scan up, scan down, or bounce (ping-pong).
- Steps are paced by an internal prescaled tick.
- Sits between switch/button inputs and the LED outputs in lab top-levels.

Parameters:
- SEL_W, 4, width of select/index; must be ≥1
- OUT_W, 2**SEL_W, one-hot output width; derived, not overridden
- TICK_DIV, 25_000_000, clk cycles per scan step; must be ≥1 (1 = step every cycle)

Ports:
- clk  input  1  system clock (100 MHz on board)
- reset  input  1  synchronous, active-high reset
- en  input  1  output enable; low forces y to zero and freezes sequencing
- mode  input  2  0=DIRECT, 1=SCAN_UP, 2=SCAN_DOWN, 3=BOUNCE
- sel  input  SEL_W  decode value (DIRECT), or preload value (on load)
- load  input  1  single-cycle strobe: idx <= sel
- y  output  OUT_W  registered one-hot output; y[k]=1 iff idx==k and en
- idx  output  SEL_W  current active index (registered)
- tick  output  1  one-cycle pulse when the prescaler wraps

Behaviour:
- All state is updated on the rising edge of clk. Reset is synchronous, active-high, and dominates all other inputs.
- Reset values: y=0, idx=0, tick=0, dir=UP, prescaler count=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 while en=1. tick=1 on the cycle the count wraps to 0.
  - en=0 clears the count and holds tick=0.
  - Mode changes do not reset the prescaler.
- Next-idx priority, highest first: reset > load > mode action.
- DIRECT: idx <= sel every cycle, independent of tick. Latency from sel to y is 1 cycle.
- SCAN_UP: on tick, idx <= idx+1, wrapping from OUT_W-1 to 0.
- SCAN_DOWN: on tick, idx <= idx-1, wrapping from 0 to OUT_W-1.
- BOUNCE:
  - On tick, move idx in direction dir.
  - At idx==OUT_W-1 with dir=UP: idx <= OUT_W-2 and dir <= DOWN.
  - At idx==0 with dir=DOWN: idx <= 1 and dir <= UP.
  - End values are shown for exactly one step; no wrap occurs.
  - SEL_W=1: the sequence alternates 0,1,0,1.
  - dir is retained across mode changes. Only reset or bounce endpoints modify it.
- load:
  - idx <= sel on the cycle load=1, in any mode, even when en=0.
  - If load and tick coincide, load wins and that step is dropped.
  - dir is unchanged by load.
- en=0:
  - y <= 0 on the next edge. idx holds except on load. No stepping occurs.
  - On en returning to 1, y shows the held idx after 1 cycle. The first step comes TICK_DIV cycles later.
- y <= en ? (1<<next_idx) : 0. y is always registered, and one-hot or zero; never multi-hot.
- Mode switch mid-sequence:
  - Takes effect on the next tick.
  - Switching to DIRECT takes effect on the next edge.
- Arithmetic is unsigned, SEL_W wide, with natural modulo wrap for SCAN modes.

Decomposition:
- Package decoder_scan_pkg:
  - mode_t enum {MODE_DIRECT, MODE_SCAN_UP, MODE_SCAN_DOWN, MODE_BOUNCE} (2 bits)
  - dir_t {DIR_UP, DIR_DOWN}
- Sub-module tick_gen:
  - Parameter DIV.
  - Ports clk, reset, en, tick.
  - Reusable prescaler for later labs.
- The decoder/sequencer remains a single always_ff block plus next-state logic in decoder_scan.

Test Plan:
1. Reset, then DIRECT with en=1, sel=4'h5 → y=16'h0020 and idx=5 one cycle later; sel=4'hF → y=16'h8000 next cycle; en=0 → y=16'h0000 next cycle.
2. SCAN_UP, TICK_DIV=4, load sel=14 → idx sequence 14,15,0,1, advancing every 4 cycles on tick; y one-hot throughout.
3. SCAN_DOWN from idx=1 → 1,0,15,14; no cycle ever shows y=0 while en=1.
4. BOUNCE with SEL_W=2, start at idx=0 → 0,1,2,3,2,1,0,1; dir flips exactly at 3 and 0.
5. In SCAN_UP with TICK_DIV=4, assert load sel=9 on the same cycle as tick → idx=9, not idx+1; next step to 10 occurs 4 cycles later.
6. Assert reset mid-BOUNCE with dir=DOWN at idx=2, together with load=1 → next cycle idx=0, y=0, tick=0, dir=UP; first tick after release occurs TICK_DIV cycles after the first en=1 cycle.
